arbitro_req_ctrl: RTL



---
 rtl/arbitro_req_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/arbitro_req_ctrl.sv
// Requester-side controller for the 4-input fixed-priority arbiter: queues strobes, owns the resource per grant.
// Optional arbiter consistency checking is compiled in with `define GRANT_CHECK_EN.

module arbitro_req_ctrl_pend #(
  parameter int PEND_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic nz_o,
  output logic ovf_o
);
  localparam logic [PEND_W-1:0] PMAX = '1;

  logic [PEND_W-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  // Saturating up/down counter; simultaneous inc and dec cancel out.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc_i && !dec_i) begin
      if (cnt_q == PMAX) ovf_d = 1'b1;
      else               cnt_d = cnt_q + PEND_W'(1);
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign nz_o  = (cnt_q != '0);
  assign ovf_o = ovf_q;
endmodule

module arbitro_req_ctrl #(
  parameter int BURST_LEN = 4,
  parameter int PEND_W    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_pulse,
  output logic [3:0] R,
  input  logic       Av,
  input  logic [3:0] Grant,
  input  logic [1:0] Grant_num,
  output logic       busy,
  output logic [1:0] owner,
  output logic [3:0] done,
  output logic [3:0] overflow,
  output logic       grant_err
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] beat_q, beat_d;
  logic [3:0] dec, nz;
  logic       take;

  // The arbiter is only consulted while idle.
  assign take = (state_q == S_IDLE) && !Av;

  for (genvar i = 0; i < 4; i++) begin : g_pend
    assign dec[i] = take && (Grant_num == 2'(i));
    arbitro_req_ctrl_pend #(.PEND_W(PEND_W)) u_pend (
      .clk   (clk),
      .rst   (rst),
      .inc_i (req_pulse[i]),
      .dec_i (dec[i]),
      .nz_o  (nz[i]),
      .ovf_o (overflow[i])
    );
  end

  assign R     = (state_q == S_IDLE) ? nz : 4'b0000;
  assign busy  = (state_q == S_BUSY);
  assign owner = owner_q;
  assign done  = (state_q == S_DONE) ? (4'b0001 << owner_q) : 4'b0000;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          owner_d = Grant_num;
          beat_d  = 8'd0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (beat_q == LAST_BEAT) state_d = S_DONE;
        else                     beat_d  = beat_q + 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      beat_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end
  end

`ifdef GRANT_CHECK_EN
  logic gerr_q, mismatch;

  // A bad grant is flagged but the transfer still follows Grant_num.
  assign mismatch = (Grant != (4'b0001 << Grant_num)) || !R[Grant_num] || (Av != (R == 4'b0000));

  always_ff @(posedge clk) begin
    if (rst)                  gerr_q <= 1'b0;
    else if (take && mismatch) gerr_q <= 1'b1;
  end

  assign grant_err = gerr_q;
`else
  logic unused_grant;
  assign unused_grant = ^Grant;
  assign grant_err    = 1'b0;
`endif
endmodule
